sipo_frame_rx: RTL

Serial-to-parallel frame receiver that sits at the far end of the serial `si`/`so` shift path. It samples one bit per clock, recognises a start-bit-framed word, checks optional even parity and the stop bit, and presents the recovered word on a valid/ready parallel port. Malformed and overrun frames are reported as one-cycle error pulses.

---
 rtl/sipo_frame_rx.sv | 158 +++++++++++++++
 1 files changed

// File: rtl/sipo_frame_rx.sv
`default_nettype none
// ============================================================================
// Module   : sipo_frame_rx
// Purpose  : Serial-to-parallel frame receiver. Samples one bit of `si` per
//            clock, recognises a start-bit framed word (LSB first), checks an
//            optional even-parity bit and the stop bit, and hands the word to
//            a valid/ready holding register. Bad frames and overruns are
//            reported as one-cycle error pulses.
// Ports    : clk        - clock, rising edge
//            rst        - asynchronous active-high reset
//            si         - serial line, idle high
//            rx_data    - received word (first bit received in bit 0)
//            rx_valid   - rx_data holds an undelivered word
//            rx_ready   - consumer accepts when rx_valid && rx_ready
//            parity_err - pulse: parity mismatch, word discarded
//            frame_err  - pulse: stop bit low, word discarded
//            overrun    - pulse: good word dropped, holding register full
// Revision : 1.0 - initial release
// ============================================================================
module sipo_frame_rx #(
    parameter int WIDTH     = 8,
    parameter int PARITY_EN = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             si,
    output logic [WIDTH-1:0] rx_data,
    output logic             rx_valid,
    input  logic             rx_ready,
    output logic             parity_err,
    output logic             frame_err,
    output logic             overrun
);

    localparam int CNT_W = (WIDTH > 2) ? $clog2(WIDTH) : 1;
    localparam logic [CNT_W-1:0] C_LAST_BIT = CNT_W'(WIDTH - 1);

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_DATA   = 3'd1;
    localparam logic [2:0] S_PARITY = 3'd2;
    localparam logic [2:0] S_STOP   = 3'd3;
    localparam logic [2:0] S_BREAK  = 3'd4;

    logic [2:0]       r_state,  w_state_d;
    logic [CNT_W-1:0] r_cnt,    w_cnt_d;
    logic [WIDTH-1:0] r_shift,  w_shift_d;
    logic             r_par,    w_par_d;
    logic [WIDTH-1:0] r_data,   w_data_d;
    logic             r_valid,  w_valid_d;
    logic             r_perr,   w_perr_d;
    logic             r_ferr,   w_ferr_d;
    logic             r_ovr,    w_ovr_d;

    logic w_par_bad;
    logic w_take;
    logic w_good;

    // Even parity: data bits XOR parity bit must be zero. Without a parity
    // bit the check is disabled and r_par is never written.
    assign w_par_bad = (PARITY_EN != 0) && ((^r_shift) ^ r_par);
    assign w_take    = r_valid && rx_ready;
    assign w_good    = (r_state == S_STOP) && si && !w_par_bad;

    always_comb begin
        w_state_d = r_state;
        w_cnt_d   = r_cnt;
        w_shift_d = r_shift;
        w_par_d   = r_par;
        w_data_d  = r_data;
        w_valid_d = r_valid;
        w_perr_d  = 1'b0;
        w_ferr_d  = 1'b0;
        w_ovr_d   = 1'b0;

        // Consumer handshake; a same-cycle load below overrides the clear.
        if (w_take) begin
            w_valid_d = 1'b0;
        end

        case (r_state)
            S_IDLE: begin
                if (!si) begin
                    w_state_d = S_DATA;
                    w_cnt_d   = '0;
                end
            end
            S_DATA: begin
                w_shift_d[r_cnt] = si;
                w_cnt_d          = r_cnt + 1'b1;
                if (r_cnt == C_LAST_BIT) begin
                    w_state_d = (PARITY_EN != 0) ? S_PARITY : S_STOP;
                end
            end
            S_PARITY: begin
                w_par_d   = si;
                w_state_d = S_STOP;
            end
            S_STOP: begin
                if (!si) begin
                    // Frame error outranks parity error.
                    w_ferr_d  = 1'b1;
                    w_state_d = S_BREAK;
                end else begin
                    w_state_d = S_IDLE;
                    if (w_par_bad) begin
                        w_perr_d = 1'b1;
                    end else if (!r_valid || w_take) begin
                        w_data_d  = r_shift;
                        w_valid_d = 1'b1;
                    end else begin
                        w_ovr_d = 1'b1;
                    end
                end
            end
            S_BREAK: begin
                // A held-low line is not a start bit; wait for it to rise.
                if (si) begin
                    w_state_d = S_IDLE;
                end
            end
            default: begin
                w_state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
            r_shift <= '0;
            r_par   <= 1'b0;
            r_data  <= '0;
            r_valid <= 1'b0;
            r_perr  <= 1'b0;
            r_ferr  <= 1'b0;
            r_ovr   <= 1'b0;
        end else begin
            r_state <= w_state_d;
            r_cnt   <= w_cnt_d;
            r_shift <= w_shift_d;
            r_par   <= w_par_d;
            r_data  <= w_data_d;
            r_valid <= w_valid_d;
            r_perr  <= w_perr_d;
            r_ferr  <= w_ferr_d;
            r_ovr   <= w_ovr_d;
        end
    end

    assign rx_data    = r_data;
    assign rx_valid   = r_valid;
    assign parity_err = r_perr;
    assign frame_err  = r_ferr;
    assign overrun    = r_ovr;

endmodule
`default_nettype wire
